// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter: one-byte holding register feeding an LSB-first shifter
// with a per-frame latched bit-period divisor.
module uart_tx_serializer #(
  parameter int unsigned PREDIV_W  = 8,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [PREDIV_W-1:0] prediv,
  input  logic                tx_enable,
  output logic                tx,
  output logic                busy
);

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned IDX_W     = 3;
  localparam logic        STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                hold_valid_q, hold_valid_d;
  logic [PREDIV_W-1:0] div_q, div_d;
  logic [PREDIV_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                stop_q, stop_d;
  logic                tx_q, tx_d;
  logic                bit_end;
  logic                load_ok;
  logic                load;

  assign in_ready = !hold_valid_q;
  assign busy     = (state_q != IDLE) | hold_valid_q;
  assign tx       = tx_q;
  assign bit_end  = (cnt_q == '0);
  assign load_ok  = hold_valid_q & tx_enable;

  // Next-state and datapath; load moves the held byte into the shifter and starts a frame
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    shift_d      = shift_q;
    hold_valid_d = hold_valid_q;
    div_d        = div_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    stop_d       = stop_q;
    tx_d         = tx_q;
    load         = 1'b0;

    if (in_valid && !hold_valid_q) begin
      hold_d       = in_data;
      hold_valid_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (load_ok) load = 1'b1;
      end
      START: begin
        if (bit_end) begin
          tx_d    = shift_q[0];
          idx_d   = '0;
          cnt_d   = div_q;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - PREDIV_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = div_q;
          if (idx_q == IDX_W'(7)) begin
            tx_d    = 1'b1;
            stop_d  = 1'b0;
            state_d = STOP;
          end else begin
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
            idx_d   = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q - PREDIV_W'(1);
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (stop_q == STOP_LAST) begin
            if (load_ok) load = 1'b1;
            else         state_d = IDLE;
          end else begin
            stop_d = 1'b1;
            cnt_d  = div_q;
          end
        end else begin
          cnt_d = cnt_q - PREDIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      shift_d      = hold_q;
      hold_valid_d = 1'b0;
      div_d        = prediv;
      cnt_d        = prediv;
      tx_d         = 1'b0;
      state_d      = START;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      shift_q      <= '0;
      hold_valid_q <= 1'b0;
      div_q        <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      stop_q       <= 1'b0;
      tx_q         <= 1'b1;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      shift_q      <= shift_d;
      hold_valid_q <= hold_valid_d;
      div_q        <= div_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      stop_q       <= stop_d;
      tx_q         <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: directed scenarios plus random frames checked
// against a bit-list model of the serial line.
module tb_uart_tx_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid, in_valid2;
  logic       in_ready, in_ready2;
  logic [7:0] prediv;
  logic       tx_enable;
  logic       tx, tx2;
  logic       busy, busy2;

  int n_tests = 0;
  int n_fail  = 0;
  bit exp_hold = 1'b0;

  uart_tx_serializer #(.PREDIV_W(8), .STOP_BITS(1)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .prediv(prediv), .tx_enable(tx_enable),
    .tx(tx), .busy(busy)
  );

  uart_tx_serializer #(.PREDIV_W(8), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid2),
    .in_ready(in_ready2), .prediv(prediv), .tx_enable(tx_enable),
    .tx(tx2), .busy(busy2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer a byte from idle, check the one-clock latency, and stop on the load edge
  task automatic start_frame(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
    exp_hold = 1'b1;
    chk("latency_tx", 32'(tx), 32'd1);
    chk("latency_ready", 32'(in_ready), 32'd0);
    tick();
    exp_hold = 1'b0;
  endtask

  // Check one 8N1 frame from the cycle after the load edge; optionally offer a
  // byte or change prediv at given cycles. loaded=1 if the next frame started.
  task automatic expect_frame(input logic [7:0] b, input int p, input int offer_at,
                              input logic [7:0] ob, input int mod_at, input int mod_val,
                              output bit loaded);
    int  len;
    int  bitn;
    bit  held;
    logic exp_bit;
    len  = 10 * (p + 1);
    held = exp_hold;
    for (int i = 0; i < len; i++) begin
      bitn = i / (p + 1);
      if (bitn == 0)      exp_bit = 1'b0;
      else if (bitn <= 8) exp_bit = b[bitn-1];
      else                exp_bit = 1'b1;
      chk("frame_tx", 32'(tx), 32'(exp_bit));
      chk("frame_busy", 32'(busy), 32'd1);
      chk("frame_ready", 32'(in_ready), 32'(!exp_hold));
      if (i == offer_at) begin
        in_valid = 1'b1;
        in_data  = ob;
      end
      if (i == mod_at) prediv = 8'(mod_val);
      held = exp_hold;
      tick();
      if (in_valid && !held) exp_hold = 1'b1;
      in_valid = 1'b0;
    end
    loaded = 1'b0;
    if (held && tx_enable) begin
      exp_hold = 1'b0;
      loaded   = 1'b1;
    end
  endtask

  initial begin
    bit         loaded;
    bit         started;
    logic [7:0] cur_b, ob;
    int         offer_at, mod_at, mod_val, len;

    reset = 1'b1; in_valid = 1'b0; in_valid2 = 1'b0; in_data = 8'h00;
    prediv = 8'd3; tx_enable = 1'b0;
    tick();
    reset = 1'b0;
    chk("reset_tx", 32'(tx), 32'd1);
    chk("reset_ready", 32'(in_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);

    // Byte held while disabled: accepted but never started
    in_valid = 1'b1; in_data = 8'h3C;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("hold_tx", 32'(tx), 32'd1);
      chk("hold_ready", 32'(in_ready), 32'd0);
      chk("hold_busy", 32'(busy), 32'd1);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_hold_tx", 32'(tx), 32'd1);
    chk("rst_hold_ready", 32'(in_ready), 32'd1);
    chk("rst_hold_busy", 32'(busy), 32'd0);
    tx_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("discard_tx", 32'(tx), 32'd1);
      chk("discard_busy", 32'(busy), 32'd0);
    end

    // 0xA5 at 4 clocks per bit; busy drops 40 clocks after tx falls
    prediv = 8'd3;
    start_frame(8'hA5);
    expect_frame(8'hA5, 3, -1, 8'h00, -1, 0, loaded);
    chk("a5_loaded", 32'(loaded), 32'd0);
    chk("a5_busy_end", 32'(busy), 32'd0);
    chk("a5_tx_end", 32'(tx), 32'd1);

    // Back-to-back 0x55 then 0x0F with no idle gap
    start_frame(8'h55);
    expect_frame(8'h55, 3, 0, 8'h0F, -1, 0, loaded);
    chk("b2b_loaded", 32'(loaded), 32'd1);
    expect_frame(8'h0F, 3, -1, 8'h00, -1, 0, loaded);
    chk("b2b_busy_end", 32'(busy), 32'd0);

    // prediv=0: 10-clock frame
    prediv = 8'd0;
    start_frame(8'h00);
    expect_frame(8'h00, 0, -1, 8'h00, -1, 0, loaded);
    chk("p0_busy_end", 32'(busy), 32'd0);

    // Two stop bits: 11-clock frame
    in_valid2 = 1'b1; in_data = 8'h00;
    tick();
    in_valid2 = 1'b0;
    chk("s2_latency_tx", 32'(tx2), 32'd1);
    tick();
    for (int i = 0; i < 11; i++) begin
      chk("s2_tx", 32'(tx2), (i < 9) ? 32'd0 : 32'd1);
      chk("s2_busy", 32'(busy2), 32'd1);
      tick();
    end
    chk("s2_busy_end", 32'(busy2), 32'd0);

    // prediv change during data bit 2 only affects the next frame
    prediv = 8'd3;
    start_frame(8'hFF);
    expect_frame(8'hFF, 3, -1, 8'h00, 13, 7, loaded);
    chk("mod_busy_end", 32'(busy), 32'd0);
    start_frame(8'hFF);
    expect_frame(8'hFF, 7, -1, 8'h00, -1, 0, loaded);
    chk("mod2_busy_end", 32'(busy), 32'd0);

    // Reset during data bit 4 with a byte queued
    prediv = 8'd3;
    start_frame(8'h86);
    for (int i = 0; i < 21; i++) begin
      if (i == 2) begin in_valid = 1'b1; in_data = 8'h11; end
      tick();
      in_valid = 1'b0;
    end
    chk("midrst_bit4", 32'(tx), 32'd0);
    chk("midrst_queued", 32'(in_ready), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_tx", 32'(tx), 32'd1);
    chk("midrst_ready", 32'(in_ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("midrst_quiet_tx", 32'(tx), 32'd1);
      chk("midrst_quiet_busy", 32'(busy), 32'd0);
    end
    exp_hold = 1'b0;

    // Random frames: random byte, divisor, queued next byte and mid-frame prediv change
    started = 1'b0;
    cur_b   = 8'h00;
    for (int k = 0; k < 26; k++) begin
      if (!started) begin
        prediv = 8'($urandom_range(0, 5));
        cur_b  = 8'($urandom);
        start_frame(cur_b);
      end
      len      = 10 * (int'(prediv) + 1);
      ob       = 8'($urandom);
      offer_at = ($urandom_range(0, 2) != 0 && k < 25) ? int'($urandom_range(0, len - 1)) : -1;
      mod_at   = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, len - 1)) : -1;
      mod_val  = int'($urandom_range(0, 5));
      expect_frame(cur_b, int'(prediv), offer_at, ob, mod_at, mod_val, loaded);
      if (loaded) begin
        started = 1'b1;
        cur_b   = ob;
      end else if (exp_hold) begin
        chk("rnd_gap_tx", 32'(tx), 32'd1);
        chk("rnd_gap_busy", 32'(busy), 32'd1);
        tick();
        exp_hold = 1'b0;
        started  = 1'b1;
        cur_b    = ob;
      end else begin
        chk("rnd_idle_busy", 32'(busy), 32'd0);
        chk("rnd_idle_tx", 32'(tx), 32'd1);
        tick();
        started = 1'b0;
      end
    end
    if (started) begin
      expect_frame(cur_b, int'(prediv), -1, 8'h00, -1, 0, loaded);
      chk("rnd_final_busy", 32'(busy), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
